// File: rtl/signed_peak4.sv
// Streaming signed peak detector: tracks the maximum of each WINDOW-sample window
// and holds it on an output handshake. Define SIGNED_PEAK4_INDEX_EN to add O_INDEX.
module signed_peak4 #(
    parameter int WIDTH  = 4,
    parameter int WINDOW = 8
) (
    input  logic                        CLK,
    input  logic                        ASYNCRESET,
    input  logic [WIDTH-1:0]            I,
    input  logic                        VALID,
    output logic                        READY,
    output logic [WIDTH-1:0]            O,
    output logic                        O_VALID,
`ifdef SIGNED_PEAK4_INDEX_EN
    output logic [$clog2(WINDOW)-1:0]   O_INDEX,
`endif
    input  logic                        O_READY
);

    localparam int CW = $clog2(WINDOW);

    typedef enum logic {
        ACCUM,
        HOLD
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] peak;
    logic             accept;
    logic             take_new;
    logic             last;
    logic [WIDTH-1:0] next_peak;
`ifdef SIGNED_PEAK4_INDEX_EN
    logic [CW-1:0]    peak_index;
    logic [CW-1:0]    next_index;
`endif

    // Strict two's-complement greater-than; this is the SGT4 compare primitive.
    function automatic logic sgt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return $signed(a) > $signed(b);
    endfunction

    assign accept    = VALID && READY;
    assign take_new  = (count == '0) || sgt(I, peak);
    assign last      = (count == CW'(WINDOW - 1));
    assign next_peak = take_new ? I : peak;
`ifdef SIGNED_PEAK4_INDEX_EN
    assign next_index = take_new ? count : peak_index;
`endif

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            state   <= ACCUM;
            count   <= '0;
            peak    <= '0;
            O       <= '0;
            O_VALID <= 1'b0;
            READY   <= 1'b0;
`ifdef SIGNED_PEAK4_INDEX_EN
            peak_index <= '0;
            O_INDEX    <= '0;
`endif
        end else begin
            case (state)
                ACCUM: begin
                    // READY comes up one edge after reset release and after each output handshake.
                    READY <= 1'b1;
                    if (accept) begin
                        peak <= next_peak;
`ifdef SIGNED_PEAK4_INDEX_EN
                        peak_index <= next_index;
`endif
                        if (last) begin
                            count   <= '0;
                            O       <= next_peak;
                            O_VALID <= 1'b1;
                            READY   <= 1'b0;
                            state   <= HOLD;
`ifdef SIGNED_PEAK4_INDEX_EN
                            O_INDEX <= next_index;
`endif
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (O_VALID && O_READY) begin
                        O_VALID <= 1'b0;
                        READY   <= 1'b1;
                        state   <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_signed_peak4.sv
// Directed bench for signed_peak4 with WINDOW=4; checks O_INDEX too when
// SIGNED_PEAK4_INDEX_EN is defined.
module tb_signed_peak4;

    logic       CLK = 1'b0;
    logic       ASYNCRESET = 1'b0;
    logic [3:0] I = '0;
    logic       VALID = 1'b0;
    logic       READY;
    logic [3:0] O;
    logic       O_VALID;
    logic       O_READY = 1'b1;
`ifdef SIGNED_PEAK4_INDEX_EN
    logic [1:0] O_INDEX;
`endif

    int vectors = 0;
    int miscompares = 0;

    signed_peak4 #(.WIDTH(4), .WINDOW(4)) dut (
        .CLK(CLK),
        .ASYNCRESET(ASYNCRESET),
        .I(I),
        .VALID(VALID),
        .READY(READY),
        .O(O),
        .O_VALID(O_VALID),
`ifdef SIGNED_PEAK4_INDEX_EN
        .O_INDEX(O_INDEX),
`endif
        .O_READY(O_READY)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present one sample and wait (bounded) until an edge accepts it.
    task automatic send_sample(input logic [3:0] v);
        bit done = 0;
        I = v;
        VALID = 1'b1;
        for (int k = 0; k < 20 && !done; k++) begin
            if (READY === 1'b1) done = 1;
            tick();
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("[TB] FAIL accept_timeout: READY never high for sample %0d", $signed(v));
        end
    endtask

    task automatic send_window(input logic [3:0] a, input logic [3:0] b,
                               input logic [3:0] c, input logic [3:0] d);
        send_sample(a);
        send_sample(b);
        send_sample(c);
        send_sample(d);
        VALID = 1'b0;
    endtask

    // Check the held result right after the final accept, then complete the handshake.
    task automatic check_result(input string name, input logic [3:0] exp_o, input logic [1:0] exp_idx);
        vectors++;
        if (O_VALID !== 1'b1 || O !== exp_o || READY !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL %s_result: O=%0d O_VALID=%b READY=%b, expected O=%0d O_VALID=1 READY=0",
                     name, $signed(O), O_VALID, READY, $signed(exp_o));
        end
`ifdef SIGNED_PEAK4_INDEX_EN
        vectors++;
        if (O_INDEX !== exp_idx) begin
            miscompares++;
            $display("[TB] FAIL %s_index: O_INDEX=%0d expected %0d", name, O_INDEX, exp_idx);
        end
`else
        if (exp_idx === 2'bxx) $display("[TB] unreachable");
`endif
        O_READY = 1'b1;
        tick();
        vectors++;
        if (O_VALID !== 1'b0 || READY !== 1'b1 || O !== exp_o) begin
            miscompares++;
            $display("[TB] FAIL %s_release: O=%0d O_VALID=%b READY=%b, expected O=%0d O_VALID=0 READY=1",
                     name, $signed(O), O_VALID, READY, $signed(exp_o));
        end
    endtask

    task automatic check_reset_outputs(input string name);
        vectors++;
        if (READY !== 1'b0 || O_VALID !== 1'b0 || O !== 4'h0) begin
            miscompares++;
            $display("[TB] FAIL %s: READY=%b O_VALID=%b O=%0d, expected all 0", name, READY, O_VALID, $signed(O));
        end
`ifdef SIGNED_PEAK4_INDEX_EN
        vectors++;
        if (O_INDEX !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL %s_index: O_INDEX=%0d expected 0", name, O_INDEX);
        end
`endif
    endtask

    task automatic release_reset();
        tick();
        ASYNCRESET = 1'b0;
        vectors++;
        if (READY !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ready_before_edge: READY=%b expected 0", READY);
        end
        tick();
        vectors++;
        if (READY !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL ready_after_edge: READY=%b expected 1", READY);
        end
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        ASYNCRESET = 1'b1;
        VALID = 1'b1;
        I = 4'd3;
        tick();
        tick();
        check_reset_outputs("reset_values");
        release_reset();
        VALID = 1'b0;
    endtask

    task automatic test_basic();
        $display("[TB] test_basic");
        O_READY = 1'b1;
        send_window(-3, 5, 2, -8);
        check_result("basic", 4'd5, 2'd1);
    endtask

    task automatic test_extremes();
        $display("[TB] test_extremes");
        send_window(-8, -8, 7, 7);
        check_result("extreme_pos", 4'd7, 2'd2);
        send_window(-8, -1, -8, -1);
        check_result("extreme_neg", 4'hF, 2'd1);
    endtask

    task automatic test_backpressure();
        $display("[TB] test_backpressure");
        O_READY = 1'b0;
        send_window(1, -2, 3, 0);
        VALID = 1'b1;
        for (int k = 0; k < 10; k++) begin
            I = 4'(k * 3 + 1);
            tick();
            vectors++;
            if (O_VALID !== 1'b1 || O !== 4'd3 || READY !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL backpressure_hold%0d: O=%0d O_VALID=%b READY=%b, expected O=3 O_VALID=1 READY=0",
                         k, $signed(O), O_VALID, READY);
            end
        end
        VALID = 1'b0;
        check_result("backpressure", 4'd3, 2'd2);
        send_window(2, 2, -5, -6);
        check_result("after_backpressure", 4'd2, 2'd0);
    endtask

    task automatic test_gapped();
        $display("[TB] test_gapped");
        send_sample(-4);
        send_sample(-7);
        VALID = 1'b0;
        I = 4'd7;
        for (int k = 0; k < 5; k++) begin
            tick();
            vectors++;
            if (O_VALID !== 1'b0 || READY !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL gap_idle%0d: O_VALID=%b READY=%b, expected O_VALID=0 READY=1", k, O_VALID, READY);
            end
        end
        send_sample(6);
        send_sample(-1);
        VALID = 1'b0;
        check_result("gapped", 4'd6, 2'd2);
    endtask

    task automatic test_reset_mid();
        $display("[TB] test_reset_mid");
        send_sample(7);
        send_sample(7);
        send_sample(7);
        VALID = 1'b0;
        #2;
        ASYNCRESET = 1'b1;
        #1;
        check_reset_outputs("reset_mid_window");
        release_reset();
        send_window(-2, -3, -4, -5);
        check_result("after_mid_reset", 4'hE, 2'd0);

        O_READY = 1'b0;
        send_window(4, 1, 1, 1);
        vectors++;
        if (O_VALID !== 1'b1 || O !== 4'd4) begin
            miscompares++;
            $display("[TB] FAIL hold_before_reset: O=%0d O_VALID=%b expected O=4 O_VALID=1", $signed(O), O_VALID);
        end
        #2;
        ASYNCRESET = 1'b1;
        #1;
        check_reset_outputs("reset_in_hold");
        O_READY = 1'b1;
        release_reset();
        send_window(1, 2, 3, -1);
        check_result("after_hold_reset", 4'd3, 2'd2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_backpressure();
        test_gapped();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

endmodule
